// File: rtl/nrisc_ula_wb_stage.sv
// Writeback stage behind NRISC_ULA: in-order result FIFO plus architectural flag register.
// Define ULA_WB_BYPASS_EN to forward a result straight through when the FIFO is empty.
module nrisc_ula_wb_stage #(
   parameter int TAM   = 16,
   parameter int DEPTH = 2,
   parameter int REG_W = 3
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [TAM-1:0]         in_data,
   input  logic [2:0]             in_flags,
   input  logic [REG_W-1:0]       in_dest,
   input  logic                   in_setf,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [TAM-1:0]         out_data,
   output logic [REG_W-1:0]       out_dest,
   output logic [2:0]             flags_q,
   output logic [$clog2(DEPTH):0] count
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL = DEPTH[AW:0];

   logic [TAM-1:0]   r_data [DEPTH];
   logic [REG_W-1:0] r_dest [DEPTH];
   logic [AW-1:0]    r_wr;
   logic [AW-1:0]    r_rd;
   logic [AW:0]      r_count;
   logic [2:0]       r_flags;

   logic w_empty;
   logic w_push;
   logic w_pop;
   logic w_wr;
   logic w_byp;
   logic w_unused;

   assign w_empty  = (r_count == '0);
   assign in_ready = (r_count != FULL);
   assign w_push   = in_valid & in_ready;

`ifdef ULA_WB_BYPASS_EN
   assign w_byp = w_empty & out_ready;
`else
   assign w_byp = 1'b0;
`endif

   // A bypassed result is consumed downstream this cycle, never stored
   assign w_wr     = w_push & ~w_byp;
   assign w_pop    = ~w_empty & out_ready;
   assign w_unused = in_flags[1];

   always_comb begin
      out_valid = 1'b0;
      out_data  = '0;
      out_dest  = '0;
      if (!w_empty) begin
         out_valid = 1'b1;
         out_data  = r_data[r_rd];
         out_dest  = r_dest[r_rd];
      end else if (w_byp) begin
         out_valid = in_valid;
         out_data  = in_data;
         out_dest  = in_dest;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_data[i] <= '0;
            r_dest[i] <= '0;
         end
         r_wr    <= '0;
         r_rd    <= '0;
         r_count <= '0;
      end else begin
         if (w_wr) begin
            r_data[r_wr] <= in_data;
            r_dest[r_wr] <= in_dest;
            r_wr         <= r_wr + 1'b1;
         end
         if (w_pop)
            r_rd <= r_rd + 1'b1;
         unique case ({w_wr, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   // Zero flag is derived here since the ALU always reports it as 0
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         r_flags <= 3'b000;
      else if (w_push && in_setf)
         r_flags <= {in_flags[2], (in_data == '0), in_flags[0]};
   end

   assign flags_q = r_flags;
   assign count   = r_count;

endmodule

// File: tb/tb_nrisc_ula_wb_stage.sv
// Scoreboard bench for nrisc_ula_wb_stage (DEPTH=2, TAM=16, REG_W=3).
module tb_nrisc_ula_wb_stage;

`ifdef ULA_WB_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif
   localparam int DEPTH = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_data;
   logic [2:0]  in_flags;
   logic [2:0]  in_dest;
   logic        in_setf;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_data;
   logic [2:0]  out_dest;
   logic [2:0]  flags_q;
   logic [1:0]  count;

   int          vectors = 0;
   int          miscompares = 0;
   logic [18:0] sb[$];
   int          m_count = 0;
   logic [2:0]  m_flags = 3'b000;

   always #5 clk = ~clk;

   nrisc_ula_wb_stage #(.TAM(16), .DEPTH(DEPTH), .REG_W(3)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .in_flags(in_flags),
      .in_dest(in_dest), .in_setf(in_setf),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_dest(out_dest),
      .flags_q(flags_q), .count(count)
   );

   // One clock: drive at negedge, compare against the model, then take the edge
   task automatic cyc(input logic v, input logic [15:0] d,
                      input logic [2:0] ds, input logic sf,
                      input logic [2:0] fl, input logic ordy);
      logic er, byp, eov, push, pop;
      logic [18:0] ex;
      @(negedge clk);
      in_valid  = v;
      in_data   = d;
      in_dest   = ds;
      in_setf   = sf;
      in_flags  = fl;
      out_ready = ordy;
      #1;
      er  = (m_count != DEPTH);
      byp = BYP && (m_count == 0) && ordy;
      eov = (m_count != 0) || (byp && v);
      vectors++;
      if (in_ready !== er) begin
         miscompares++;
         $display("FAIL in_ready got %b exp %b", in_ready, er);
      end
      vectors++;
      if (out_valid !== eov) begin
         miscompares++;
         $display("FAIL out_valid got %b exp %b", out_valid, eov);
      end
      if (eov) begin
         ex = (m_count != 0) ? sb[0] : {ds, d};
         vectors++;
         if ({out_dest, out_data} !== ex) begin
            miscompares++;
            $display("FAIL out_entry got %h/%h exp %h/%h",
                     out_dest, out_data, ex[18:16], ex[15:0]);
         end
      end
      vectors++;
      if (count !== 2'(m_count)) begin
         miscompares++;
         $display("FAIL count got %0d exp %0d", count, m_count);
      end
      vectors++;
      if (flags_q !== m_flags) begin
         miscompares++;
         $display("FAIL flags_q got %b exp %b", flags_q, m_flags);
      end
      push = v && er;
      pop  = (m_count != 0) && ordy;
      if (pop) void'(sb.pop_front());
      if (push && !byp) sb.push_back({ds, d});
      if (push && sf) m_flags = {fl[2], (d == 16'h0), fl[0]};
      m_count = sb.size();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input logic ordy);
      cyc(1'b0, 16'h0, 3'd0, 1'b0, 3'b000, ordy);
   endtask

   task automatic model_reset();
      sb.delete();
      m_count = 0;
      m_flags = 3'b000;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      in_valid = 1'b0; in_data = '0; in_dest = '0;
      in_setf = 1'b0; in_flags = '0; out_ready = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      model_reset();
      #1;
      vectors++;
      if ({out_valid, in_ready, count, flags_q} !== {1'b0, 1'b1, 2'd0, 3'b000}) begin
         miscompares++;
         $display("FAIL reset_state got ov=%b ir=%b cnt=%0d fl=%b",
                  out_valid, in_ready, count, flags_q);
      end
      vectors++;
      if ({out_data, out_dest} !== 19'h0) begin
         miscompares++;
         $display("FAIL reset_outputs got %h/%h exp 0/0", out_dest, out_data);
      end
   endtask

   task automatic test_single();
      cyc(1'b1, 16'h1234, 3'd3, 1'b1, 3'b101, 1'b1);
      vectors++;
      if (BYP == 1'b0 && {out_valid, out_data, out_dest} !== {1'b1, 16'h1234, 3'd3}) begin
         miscompares++;
         $display("FAIL single got ov=%b %h/%h exp 1 3/1234",
                  out_valid, out_dest, out_data);
      end
      vectors++;
      if (flags_q !== 3'b101) begin
         miscompares++;
         $display("FAIL single_flags got %b exp 101", flags_q);
      end
      idle(1'b1);
   endtask

   task automatic test_zero_flag();
      cyc(1'b1, 16'h0000, 3'd1, 1'b1, 3'b001, 1'b1);
      vectors++;
      if (flags_q !== 3'b011) begin
         miscompares++;
         $display("FAIL zero_flag got %b exp 011", flags_q);
      end
      cyc(1'b1, 16'h0005, 3'd2, 1'b0, 3'b100, 1'b1);
      vectors++;
      if (flags_q !== 3'b011) begin
         miscompares++;
         $display("FAIL flag_hold got %b exp 011", flags_q);
      end
      cyc(1'b1, 16'h8000, 3'd4, 1'b1, 3'b110, 1'b1);
      vectors++;
      if (flags_q !== 3'b100) begin
         miscompares++;
         $display("FAIL flag_ignore_z got %b exp 100", flags_q);
      end
      idle(1'b1);
      idle(1'b1);
   endtask

   task automatic test_full();
      cyc(1'b1, 16'hAAAA, 3'd5, 1'b0, 3'b000, 1'b0);
      cyc(1'b1, 16'hBBBB, 3'd6, 1'b0, 3'b000, 1'b0);
      vectors++;
      if ({count, in_ready} !== {2'd2, 1'b0}) begin
         miscompares++;
         $display("FAIL full got cnt=%0d ir=%b exp 2 0", count, in_ready);
      end
      cyc(1'b1, 16'hCCCC, 3'd7, 1'b1, 3'b101, 1'b0);
      vectors++;
      if ({count, flags_q} !== {2'd2, 3'b100}) begin
         miscompares++;
         $display("FAIL third_push got cnt=%0d fl=%b exp 2 100", count, flags_q);
      end
      idle(1'b1);
      vectors++;
      if ({in_ready, out_data} !== {1'b1, 16'hBBBB}) begin
         miscompares++;
         $display("FAIL drain1 got ir=%b d=%h exp 1 BBBB", in_ready, out_data);
      end
      idle(1'b1);
      idle(1'b1);
   endtask

   task automatic test_back_to_back();
      int n = 0;
      int cycles = 0;
      logic ordy = 1'b1;
      while (n < 10 && cycles < 40) begin
         cyc(1'b1, 16'h1000 + 16'(n * 16'h0111), 3'(n), 1'b1,
             3'(n), ordy);
         if (in_valid && (m_count < DEPTH || sb.size() <= DEPTH)) begin
         end
         n = n + ((sb.size() > 0 && sb[sb.size()-1][15:0] ==
                  16'h1000 + 16'(n * 16'h0111)) ||
                  (BYP && in_data == 16'h1000 + 16'(n * 16'h0111) &&
                   sb.size() == 0) ? 1 : 0);
         vectors++;
         if (count > 2'd2) begin
            miscompares++;
            $display("FAIL wrap_count got %0d exp <=2", count);
         end
         ordy = ~ordy;
         cycles++;
      end
      vectors++;
      if (n != 10) begin
         miscompares++;
         $display("FAIL wrap_pushes got %0d exp 10", n);
      end
      repeat (4) idle(1'b1);
      vectors++;
      if ({count, out_valid} !== {2'd0, 1'b0}) begin
         miscompares++;
         $display("FAIL wrap_drain got cnt=%0d ov=%b exp 0 0", count, out_valid);
      end
   endtask

   task automatic test_bypass();
      cyc(1'b1, 16'hBEEF, 3'd2, 1'b0, 3'b000, 1'b1);
      vectors++;
      if (count !== (BYP ? 2'd0 : 2'd1)) begin
         miscompares++;
         $display("FAIL bypass_count got %0d exp %0d", count, BYP ? 0 : 1);
      end
      idle(1'b1);
   endtask

   task automatic test_reset_mid();
      cyc(1'b1, 16'h1111, 3'd1, 1'b0, 3'b000, 1'b0);
      cyc(1'b1, 16'h2222, 3'd2, 1'b1, 3'b101, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      vectors++;
      if ({count, out_valid, flags_q} !== {2'd0, 1'b0, 3'b000}) begin
         miscompares++;
         $display("FAIL reset_mid got cnt=%0d ov=%b fl=%b", count, out_valid, flags_q);
      end
      @(posedge clk);
      #1;
      rst = 1'b1;
      model_reset();
      idle(1'b1);
      idle(1'b1);
   endtask

   initial begin
      test_reset();
      test_single();
      test_zero_flag();
      test_full();
      test_back_to_back();
      test_bypass();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
